// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage sequencer sitting behind the EX/MEM register. It turns a load or
// store into a single req/ready transaction on the variable-latency data
// memory, places store bytes on the right lanes, extracts and sign-extends
// load data, stalls the front of the pipeline while the access is in flight
// and parks the core on a halt instruction.
//
// Ports
//   clock, reset          pipeline clock, asynchronous active-high reset
//   memtoReg, memWrite    EX/MEM load / store qualifiers
//   sb, lh, ld            access size (store: sb=byte else word;
//                         load: ld=word, lh=half, neither=byte)
//   halt                  EX/MEM halt instruction
//   ALUresult             effective byte address
//   readData2             store source data
//   mem_req, mem_we       memory request and write strobe
//   mem_addr              word address (ALUresult[ADDR_W-1:2])
//   mem_be, mem_wdata     byte enables and lane-placed store data
//   mem_ready, mem_rdata  memory completion and read word
//   stall                 freezes PC, IF/ID, ID/EX and EX/MEM
//   loadData              extended load result for MEM/WB
//   misaligned            sticky alignment error flag
//   halted                core parked
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memtoReg,
    input  logic              memWrite,
    input  logic              sb,
    input  logic              lh,
    input  logic              ld,
    input  logic              halt,
    input  logic [ADDR_W-1:0] ALUresult,
    input  logic [31:0]       readData2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic [31:0]       loadData,
    output logic              misaligned,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, HALTED} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Decode of the instruction currently held in EX/MEM
    // ------------------------------------------------------------------
    logic        access;
    logic        is_store;
    logic [1:0]  addr_lo;
    size_t       size_now;
    logic        misalign_now;
    logic [3:0]  be_now;
    logic [31:0] wdata_now;

    assign access   = memtoReg | memWrite;
    // A (never decoded) load+store combination behaves as a store.
    assign is_store = memWrite;
    assign addr_lo  = ALUresult[1:0];

    always_comb begin
        size_now = SZ_BYTE;
        if (is_store) begin
            size_now = sb ? SZ_BYTE : SZ_WORD;
        end else if (ld) begin
            size_now = SZ_WORD;
        end else if (lh) begin
            size_now = SZ_HALF;
        end
    end

    always_comb begin
        misalign_now = 1'b0;
        case (size_now)
            SZ_HALF: misalign_now = addr_lo[0];
            SZ_WORD: misalign_now = (addr_lo != 2'b00);
            default: misalign_now = 1'b0;
        endcase
    end

    // Byte enables reflect the access size for loads as well as stores.
    always_comb begin
        be_now = 4'b1111;
        case (size_now)
            SZ_BYTE: be_now = 4'b0001 << addr_lo;
            SZ_HALF: be_now = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be_now = 4'b1111;
        endcase
    end

    // Byte stores replicate the low byte on every lane; the enables pick one.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            assign wdata_now[8*gi +: 8] = (is_store && size_now == SZ_BYTE) ?
                                          readData2[7:0] : readData2[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request fields captured on entry to BUSY so the memory sees stable
    // values for the whole transaction.
    // ------------------------------------------------------------------
    logic              we_reg;
    logic [ADDR_W-3:0] addr_reg;
    logic [3:0]        be_reg;
    logic [31:0]       wdata_reg;
    size_t             size_reg;
    logic [1:0]        lo_reg;
    logic [31:0]       load_data_reg;
    logic              misaligned_reg;

    // ------------------------------------------------------------------
    // Load extraction from the returned word
    // ------------------------------------------------------------------
    logic [7:0]  rd_byte [4];
    logic [31:0] load_ext;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_rlane
            assign rd_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        load_ext = mem_rdata;
        case (size_reg)
            SZ_BYTE: load_ext = {{24{rd_byte[lo_reg][7]}}, rd_byte[lo_reg]};
            SZ_HALF: load_ext = lo_reg[1] ?
                                {{16{mem_rdata[31]}}, mem_rdata[31:16]} :
                                {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state and control
    // ------------------------------------------------------------------
    logic stall_comb;
    logic req_comb;
    logic capture_req;
    logic flag_misalign;
    logic capture_load;

    always_comb begin
        state_next    = state_reg;
        stall_comb    = 1'b0;
        req_comb      = 1'b0;
        capture_req   = 1'b0;
        flag_misalign = 1'b0;
        capture_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (access) begin
                    // Both aligned and misaligned accesses hold the pipe for
                    // this cycle; a misaligned one skips memory entirely.
                    stall_comb = 1'b1;
                    if (misalign_now) begin
                        flag_misalign = 1'b1;
                        state_next    = DONE;
                    end else begin
                        capture_req = 1'b1;
                        state_next  = BUSY;
                    end
                end else if (halt) begin
                    state_next = HALTED;
                end
            end
            BUSY: begin
                req_comb   = 1'b1;
                stall_comb = 1'b1;
                if (mem_ready) begin
                    capture_load = ~we_reg;
                    state_next   = DONE;
                end
            end
            DONE: begin
                // EX/MEM advances at the end of this cycle.
                state_next = IDLE;
            end
            HALTED: begin
                stall_comb = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            be_reg         <= 4'b0000;
            wdata_reg      <= 32'h0;
            size_reg       <= SZ_BYTE;
            lo_reg         <= 2'b00;
            load_data_reg  <= 32'h0;
            misaligned_reg <= 1'b0;
        end else begin
            if (capture_req) begin
                we_reg    <= is_store;
                addr_reg  <= ALUresult[ADDR_W-1:2];
                be_reg    <= be_now;
                wdata_reg <= wdata_now;
                size_reg  <= size_now;
                lo_reg    <= addr_lo;
            end
            if (flag_misalign) begin
                misaligned_reg <= 1'b1;
                load_data_reg  <= 32'h0;
            end
            if (capture_load) begin
                load_data_reg <= load_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Gating with reset makes request and stall drop in the very
    // cycle reset is raised, even while EX/MEM still presents an access.
    // ------------------------------------------------------------------
    assign mem_req    = req_comb & ~reset;
    assign mem_we     = req_comb & we_reg & ~reset;
    assign stall      = stall_comb & ~reset;
    assign mem_addr   = addr_reg;
    assign mem_be     = be_reg;
    assign mem_wdata  = wdata_reg;
    assign loadData   = load_data_reg;
    assign misaligned = misaligned_reg;
    assign halted     = (state_reg == HALTED);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        memtoReg;
    logic        memWrite;
    logic        sb;
    logic        lh;
    logic        ld;
    logic        halt;
    logic [31:0] ALUresult;
    logic [31:0] readData2;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] loadData;
    logic        misaligned;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Reference state: last loaded value and sticky alignment flag.
    logic [31:0] model_load = 32'h0;
    logic        model_mis  = 1'b0;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .memtoReg(memtoReg), .memWrite(memWrite),
        .sb(sb), .lh(lh), .ld(ld), .halt(halt),
        .ALUresult(ALUresult), .readData2(readData2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall), .loadData(loadData),
        .misaligned(misaligned), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected load value from plain arithmetic on the returned word.
    function automatic logic [31:0] exp_load(input int sz, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int s;
        v = rd >> ((a % 4) * 8);
        if (sz == 4) return rd;
        if (sz == 2) begin
            s = int'(v % 65536);
            if (s >= 32768) s -= 65536;
            return 32'(s);
        end
        s = int'(v % 256);
        if (s >= 128) s -= 256;
        return 32'(s);
    endfunction

    task automatic clear_inputs();
        memtoReg = 0; memWrite = 0; sb = 0; lh = 0; ld = 0; halt = 0;
        mem_ready = 0;
    endtask

    // One memory instruction; entered and left at posedge+1 with FSM idle.
    task automatic do_access(input bit st, input bit sbf, input bit lhf, input bit ldf,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd, input int lat, input string nm);
        int sz;
        int stalls;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        sz   = st ? (sbf ? 1 : 4) : (ldf ? 4 : (lhf ? 2 : 1));
        be_e = 4'(((1 << sz) - 1) << (a % 4));
        wd_e = (st && sbf) ? (d % 256) * 32'h01010101 : d;
        memWrite = st; memtoReg = !st; sb = sbf; lh = lhf; ld = ldf;
        ALUresult = a; readData2 = d; stalls = 0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s.idle_stall got %b expected 1", nm, stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s.idle_req got %b expected 0", nm, mem_req); end
        if (stall === 1'b1) stalls++;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clock); #1;
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            #1;
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL %s.busy_req got %b expected 1", nm, mem_req); end
            total++; if (mem_we !== st) begin bad++; $display("FAIL %s.we got %b expected %b", nm, mem_we, st); end
            total++; if (mem_addr !== 30'(a >> 2)) begin bad++; $display("FAIL %s.addr got %h expected %h", nm, mem_addr, 30'(a >> 2)); end
            total++; if (mem_be !== be_e) begin bad++; $display("FAIL %s.be got %b expected %b", nm, mem_be, be_e); end
            if (st) begin
                total++; if (mem_wdata !== wd_e) begin bad++; $display("FAIL %s.wdata got %h expected %h", nm, mem_wdata, wd_e); end
            end
            if (stall === 1'b1) stalls++;
        end
        @(posedge clock); #1;
        mem_ready = 0;
        if (!st) model_load = exp_load(sz, a, rd);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s.done_stall got %b expected 0", nm, stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s.done_req got %b expected 0", nm, mem_req); end
        total++; if (loadData !== model_load) begin bad++; $display("FAIL %s.loadData got %h expected %h", nm, loadData, model_load); end
        total++; if (misaligned !== model_mis) begin bad++; $display("FAIL %s.misaligned got %b expected %b", nm, misaligned, model_mis); end
        total++; if (stalls != lat + 1) begin bad++; $display("FAIL %s.stall_cycles got %0d expected %0d", nm, stalls, lat + 1); end
        $display("txn %s st=%0d addr=%h lat=%0d loadData=%h", nm, st, a, lat, loadData);
        clear_inputs();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs(); ALUresult = 0; readData2 = 0; mem_rdata = 0;
        @(posedge clock); @(posedge clock); #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset.stall got %b expected 0", stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset.mem_req got %b expected 0", mem_req); end
        total++; if (loadData !== 32'h0) begin bad++; $display("FAIL reset.loadData got %h expected 0", loadData); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset.misaligned got %b expected 0", misaligned); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset.halted got %b expected 0", halted); end
        $display("txn reset");
        reset = 0;
    endtask

    task automatic test_word_load();
        do_access(0, 0, 0, 1, 32'h100, 32'h0, 32'h89ABCDEF, 3, "word_load");
        total++; if (loadData !== 32'h89ABCDEF) begin bad++; $display("FAIL word_load.value got %h expected 89abcdef", loadData); end
    endtask

    task automatic test_sb_store();
        do_access(1, 1, 0, 0, 32'h203, 32'h000000A5, 32'h0, 1, "sb_store");
        do_access(1, 0, 0, 0, 32'h4C, 32'hDEADBEEF, 32'h0, 2, "sw_store");
    endtask

    task automatic test_lh();
        do_access(0, 0, 1, 0, 32'h12, 32'h0, 32'h80017FFF, 1, "lh_hi");
        total++; if (loadData !== 32'hFFFF8001) begin bad++; $display("FAIL lh_hi.value got %h expected ffff8001", loadData); end
        do_access(0, 0, 1, 0, 32'h10, 32'h0, 32'h80017FFF, 2, "lh_lo");
        total++; if (loadData !== 32'h00007FFF) begin bad++; $display("FAIL lh_lo.value got %h expected 00007fff", loadData); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit st, sbf, lhf, ldf;
            logic [31:0] a;
            int pick;
            st = 1'($urandom_range(0, 1));
            sbf = 0; lhf = 0; ldf = 0;
            a = $urandom;
            if (st) begin
                sbf = 1'($urandom_range(0, 1));
                if (!sbf) a = a & ~32'h3;
            end else begin
                pick = $urandom_range(0, 2);
                if (pick == 1) begin lhf = 1; a = a & ~32'h1; end
                if (pick == 2) begin ldf = 1; a = a & ~32'h3; end
            end
            do_access(st, sbf, lhf, ldf, a, $urandom, $urandom, $urandom_range(1, 4), "rand");
        end
    endtask

    task automatic test_misaligned();
        memtoReg = 1; lh = 1; ALUresult = 32'h11;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis.idle_stall got %b expected 1", stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis.idle_req got %b expected 0", mem_req); end
        @(posedge clock); #1;
        model_mis = 1; model_load = 0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis.done_req got %b expected 0", mem_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mis.done_stall got %b expected 0", stall); end
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis.flag got %b expected 1", misaligned); end
        total++; if (loadData !== 32'h0) begin bad++; $display("FAIL mis.loadData got %h expected 0", loadData); end
        $display("txn misaligned lh addr=00000011 misaligned=%b", misaligned);
        clear_inputs();
        @(posedge clock); #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis.sticky got %b expected 1", misaligned); end
        do_access(0, 0, 0, 1, 32'h300, 32'h0, 32'h13572468, 1, "after_mis");
    endtask

    task automatic test_reset_busy();
        memtoReg = 1; ld = 1; ALUresult = 32'h40;
        @(posedge clock); #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_busy.req got %b expected 1", mem_req); end
        reset = 1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_busy.req_drop got %b expected 0", mem_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_busy.stall got %b expected 0", stall); end
        reset = 0;
        clear_inputs();
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        model_load = 0; model_mis = 0;
        @(posedge clock); #1;
        mem_ready = 0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_busy.late_req got %b expected 0", mem_req); end
        total++; if (loadData !== 32'h0) begin bad++; $display("FAIL rst_busy.loadData got %h expected 0", loadData); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL rst_busy.misaligned got %b expected 0", misaligned); end
        $display("txn reset_in_busy loadData=%h", loadData);
        @(posedge clock); #1;
        do_access(0, 0, 0, 0, 32'h7, 32'h0, 32'h80000000, 1, "post_rst");
    endtask

    task automatic test_halt();
        for (int i = 0; i < 6; i++) begin
            ALUresult = $urandom;
            #1;
            total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu.stall got %b expected 0", stall); end
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL alu.req got %b expected 0", mem_req); end
            $display("txn alu cycle %0d stall=%b", i, stall);
            @(posedge clock); #1;
        end
        halt = 1;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt.early got %b expected 0", halted); end
        @(posedge clock); #1;
        halt = 0; memtoReg = 1; ld = 1; ALUresult = 32'h80;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt.halted got %b expected 1", halted); end
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL halt.stall got %b expected 1", stall); end
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL halt.req got %b expected 0", mem_req); end
            $display("txn halted cycle %0d halted=%b", i, halted);
            @(posedge clock); #1;
        end
        reset = 1;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_rst.halted got %b expected 0", halted); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL halt_rst.stall got %b expected 0", stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL halt_rst.req got %b expected 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL halt_rst.we got %b expected 0", mem_we); end
        total++; if (loadData !== 32'h0) begin bad++; $display("FAIL halt_rst.loadData got %h expected 0", loadData); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL halt_rst.misaligned got %b expected 0", misaligned); end
        $display("txn halt_reset halted=%b stall=%b", halted, stall);
        clear_inputs();
        @(posedge clock); #1;
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_sb_store();
        test_lh();
        test_random();
        test_misaligned();
        test_reset_busy();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage. It sits directly behind the EX/MEM pipeline register and drives the single-ported, variable-latency data memory through a req/ready handshake. It generates byte enables and store-data lane placement, and extracts and sign-extends load data. It stalls the front of the pipeline while an access is outstanding and parks the core on a halt.

## Interface
Parameters:
- ADDR_W, 32, byte-address width taken from ALUresult

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces FSM to IDLE and all registered outputs to reset values immediately
- memtoReg  in  1  EX/MEM: instruction is a load
- memWrite  in  1  EX/MEM: instruction is a store
- sb  in  1  store size byte (else word)
- lh  in  1  load size halfword
- ld  in  1  load size word; load with neither lh nor ld is byte
- halt  in  1  EX/MEM: halt instruction
- ALUresult  in  32  effective byte address
- readData2  in  32  store source data
- mem_req  out  1  access request to data memory
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr  out  30  word address = ALUresult[31:2]
- mem_be  out  4  byte enables, bit i = byte i (little-endian)
- mem_wdata  out  32  lane-placed store data
- mem_ready  in  1  memory completes the request this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1 on a read
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM this cycle
- loadData  out  32  extended load result for MEM/WB
- misaligned  out  1  sticky alignment error flag
- halted  out  1  core parked

## Operation
- States: IDLE, BUSY, DONE, HALTED.
- access = memtoReg | memWrite.
- IDLE:
  - access=1 and address aligned: stall=1 (combinational); next state BUSY.
  - access=1 and misaligned (lh with addr[0]=1, or word with addr[1:0]!=0): no memory request; set misaligned; loadData<=0; next state DONE.
  - halt=1 and access=0: next state HALTED.
  - Otherwise stall=0 and the FSM stays in IDLE, so non-memory instructions pass with no bubble.
- BUSY:
  - mem_req=1 and stall=1.
  - mem_we, mem_addr, mem_be and mem_wdata are driven from the held EX/MEM values.
  - mem_ready=1: on a read, capture the extracted mem_rdata into loadData; next state DONE.
  - mem_ready=0: remain in BUSY; no timeout.
- DONE: stall=0 and mem_req=0. EX/MEM advances at the end of this cycle and loadData holds the result. Next state IDLE.
- HALTED: stall=1 and halted=1 in every cycle; only reset exits this state.
- Store lanes:
  - sb: mem_be = 1<<addr[1:0]; mem_wdata = {4{readData2[7:0]}}.
  - Word store: mem_be = 4'b1111; mem_wdata = readData2.
- Load extraction:
  - Byte: the byte selected by addr[1:0], sign-extended.
  - Half: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16]; sign-extended.
  - Word: the full 32-bit word.
  - For a read, mem_be reflects the access size so memory can ignore it.
- memtoReg and memWrite both set is not generated by decode; if it occurs, it is treated as a store.
- misaligned is cleared only by reset.

## Timing
- Reset values: FSM=IDLE, mem_req=0, stall=0, loadData=0, misaligned=0, halted=0.
- Memory access latency: 1 (IDLE) + N (BUSY, N ≥ 1 cycles including the mem_ready cycle) + 1 (DONE). The minimum is 3 cycles, of which 2 are stalled.
- mem_req is asserted only in BUSY and deasserts on the edge after mem_ready. Back-to-back memory instructions therefore always see at least one req-low cycle (DONE).
- loadData is stable from the first cycle of DONE until the next capture.
- Reset asserted mid-BUSY drops mem_req within the same cycle. Any in-flight memory response after that is ignored.

## Test plan
- Word load, addr 0x100, mem_ready after 3 BUSY cycles, mem_rdata 0x89ABCDEF -> stall high for 4 cycles, then loadData=0x89ABCDEF in DONE with stall=0.
- sb, addr 0x203, readData2 0x000000A5 -> mem_we=1, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x80.
- lh, addr 0x12, mem_rdata 0x8001_7FFF -> loadData=0xFFFF8001; repeat with addr 0x10 -> loadData=0x00007FFF.
- lh at addr 0x11 -> mem_req never asserted, misaligned=1 and stays 1, one stall cycle, then DONE.
- ALU-only stream followed by halt=1 -> stall=0 throughout the stream, then halted=1 and stall=1 permanently; assert reset -> all outputs return to 0.
- Reset pulsed during BUSY -> mem_req=0 and stall=0 immediately; a late mem_ready is ignored and loadData=0.
